// File: rtl/pluse_us_chk.sv
// Consumer-side check of the 1 us tick: locks onto its period, counts faults, derives a 1 ms tick.
// Outputs are registered one cycle after the sampled pulse; pluse_us is sampled every cycle, no backpressure.
module pluse_us_chk #(
   parameter int EXP_CYC  = 100,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int TIMEOUT  = 255,
   parameter int MS_DIV   = 1000
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       pluse_us,
   input  logic       clr_err,
   output logic       locked,
   output logic       err,
   output logic [7:0] err_cnt,
   output logic [7:0] period,
   output logic       pluse_ms
);

   localparam logic [7:0] MEAS_LO = 8'(EXP_CYC - TOL);
   localparam logic [7:0] MEAS_HI = 8'(EXP_CYC + TOL);
   localparam logic [7:0] G_MAX   = 8'(TIMEOUT);
   localparam logic [3:0] LOCK_N  = 4'(LOCK_CNT);
   localparam logic [9:0] MS_LAST = 10'(MS_DIV - 1);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_ACQ    = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_g;
   logic [3:0] r_good_cnt;
   logic [3:0] w_good_cnt_nxt;
   logic [9:0] r_ms_cnt;
   logic       r_locked;
   logic       r_err;
   logic [7:0] r_err_cnt;
   logic [7:0] r_period;
   logic       r_pluse_ms;

   logic       w_good;
   logic       w_timeout;
   logic       w_fault;
   logic       w_load_period;
   logic       w_ms_cnt_en;
   logic       w_ms_wrap;

   // r_g in a pulse cycle is the measured period
   assign w_good    = (r_g >= MEAS_LO) && (r_g <= MEAS_HI);
   assign w_timeout = !pluse_us && (r_g == G_MAX);
   assign w_ms_wrap = (r_ms_cnt == MS_LAST);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_state    <= S_SEARCH;
         r_good_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_good_cnt_nxt = r_good_cnt;
      w_fault        = 1'b0;
      w_load_period  = 1'b0;
      w_ms_cnt_en    = 1'b0;
      case (r_state)
         S_SEARCH: begin
            if (pluse_us) begin
               w_state_nxt    = S_ACQ;
               w_good_cnt_nxt = '0;
            end
         end
         S_ACQ: begin
            if (pluse_us) begin
               w_load_period = 1'b1;
               if (!w_good) begin
                  w_good_cnt_nxt = '0;
               end else if (r_good_cnt + 4'd1 == LOCK_N) begin
                  w_state_nxt    = S_LOCKED;
                  w_good_cnt_nxt = '0;
               end else begin
                  w_good_cnt_nxt = r_good_cnt + 4'd1;
               end
            end else if (w_timeout) begin
               w_state_nxt    = S_SEARCH;
               w_good_cnt_nxt = '0;
            end
         end
         S_LOCKED: begin
            if (pluse_us) begin
               w_load_period = 1'b1;
               if (w_good) begin
                  w_ms_cnt_en = 1'b1;
               end else begin
                  w_fault        = 1'b1;
                  w_state_nxt    = S_ACQ;
                  w_good_cnt_nxt = '0;
               end
            end else if (w_timeout) begin
               // leaving LOCKED stops further timeout faults until a pulse relocks
               w_fault     = 1'b1;
               w_state_nxt = S_SEARCH;
            end
         end
         default: begin
            w_state_nxt    = S_SEARCH;
            w_good_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_g        <= '0;
         r_period   <= '0;
         r_locked   <= 1'b0;
         r_ms_cnt   <= '0;
         r_pluse_ms <= 1'b0;
      end else begin
         if (pluse_us) begin
            r_g <= 8'd1;
         end else if (r_g != G_MAX) begin
            r_g <= r_g + 8'd1;
         end
         if (w_load_period) begin
            r_period <= r_g;
         end
         r_locked <= (w_state_nxt == S_LOCKED);
         if (w_ms_cnt_en) begin
            r_ms_cnt <= w_ms_wrap ? 10'd0 : r_ms_cnt + 10'd1;
         end else if (w_state_nxt != S_LOCKED) begin
            r_ms_cnt <= '0;
         end
         r_pluse_ms <= w_ms_cnt_en && w_ms_wrap;
      end
   end

   // a fault in the same cycle as clr_err restarts the count at one
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_fault) begin
         r_err     <= 1'b1;
         r_err_cnt <= clr_err ? 8'd1 : ((r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1);
      end else if (clr_err) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end
   end

   assign locked   = r_locked;
   assign err      = r_err;
   assign err_cnt  = r_err_cnt;
   assign period   = r_period;
   assign pluse_ms = r_pluse_ms;

endmodule

// File: tb/tb_pluse_us_chk.sv
// Bench for pluse_us_chk with scaled-down timing (12-cycle period, 40-cycle timeout, 20 pulses per ms tick).
// Fixed vectors, directed corner sequences and random gaps, all checked every cycle against a gap-based model.
module tb_pluse_us_chk;

   localparam int B_EXP  = 12;
   localparam int B_TOL  = 1;
   localparam int B_LOCK = 4;
   localparam int B_TO   = 40;
   localparam int B_MS   = 20;

   logic       clk_sys;
   logic       rst;
   logic       pluse_us;
   logic       clr_err;
   logic       locked;
   logic       err;
   logic [7:0] err_cnt;
   logic [7:0] period;
   logic       pluse_ms;

   pluse_us_chk #(
      .EXP_CYC (B_EXP),
      .TOL     (B_TOL),
      .LOCK_CNT(B_LOCK),
      .TIMEOUT (B_TO),
      .MS_DIV  (B_MS)
   ) dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .pluse_us(pluse_us),
      .clr_err (clr_err),
      .locked  (locked),
      .err     (err),
      .err_cnt (err_cnt),
      .period  (period),
      .pluse_ms(pluse_ms)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: elapsed cycles since the last pulse (or reset) decide everything.
   typedef enum int {M_SEARCH, M_ACQ, M_LOCKED} mode_t;
   mode_t  m_mode;
   longint m_cyc = 0;
   longint m_last = 0;
   int     m_streak;
   int     m_locked_good;
   bit     m_err;
   int     m_errs;
   int     m_period;
   bit     m_tick;

   task automatic model_reset();
      m_mode        = M_SEARCH;
      m_last        = m_cyc;
      m_streak      = 0;
      m_locked_good = 0;
      m_err         = 0;
      m_errs        = 0;
      m_period      = 0;
      m_tick        = 0;
   endtask

   task automatic model_step(input bit p, input bit c);
      longint gap;
      int     meas;
      int     dev;
      bit     good;
      bit     fault;
      gap   = m_cyc - m_last;
      meas  = (gap > B_TO) ? B_TO : int'(gap);
      dev   = meas - B_EXP;
      good  = (dev <= B_TOL) && (-dev <= B_TOL);
      fault = 0;
      m_tick = 0;
      if (p) begin
         if (m_mode != M_SEARCH) m_period = meas;
         case (m_mode)
            M_SEARCH: begin m_mode = M_ACQ; m_streak = 0; end
            M_ACQ: begin
               m_streak = good ? m_streak + 1 : 0;
               if (m_streak == B_LOCK) begin m_mode = M_LOCKED; m_locked_good = 0; end
            end
            default: begin
               if (good) begin
                  m_locked_good++;
                  m_tick = (m_locked_good % B_MS) == 0;
               end else begin
                  fault = 1; m_mode = M_ACQ; m_streak = 0;
               end
            end
         endcase
         m_last = m_cyc;
      end else if (m_mode != M_SEARCH && gap == B_TO) begin
         fault  = (m_mode == M_LOCKED);
         m_mode = M_SEARCH;
      end
      if (fault) begin
         m_err  = 1;
         m_errs = c ? 1 : ((m_errs >= 255) ? 255 : m_errs + 1);
      end else if (c) begin
         m_err  = 0;
         m_errs = 0;
      end
      m_cyc++;
   endtask

   int     ms_seen;
   longint ms_stamp[2];

   task automatic step(input bit p, input bit c);
      logic [18:0] act;
      logic [18:0] exp;
      pluse_us = p;
      clr_err  = c;
      @(posedge clk_sys);
      model_step(p, c);
      @(negedge clk_sys);
      pluse_us = 1'b0;
      clr_err  = 1'b0;
      act = {locked, err, err_cnt, period, pluse_ms};
      exp = {m_mode == M_LOCKED, m_err, 8'(m_errs), 8'(m_period), m_tick};
      chk("model_cycle{locked,err,err_cnt,period,pluse_ms}", 32'(act), 32'(exp));
      if (pluse_ms) begin
         if (ms_seen < 2) ms_stamp[ms_seen] = m_cyc;
         ms_seen++;
      end
   endtask

   // Pulse lands exactly gap cycles after the previous pulse step.
   task automatic pulse_after(input int gap, input bit c);
      for (int i = 1; i < gap; i++) step(1'b0, 1'b0);
      step(1'b1, c);
   endtask

   task automatic relock();
      for (int i = 0; i < B_LOCK; i++) pulse_after(B_EXP, 1'b0);
   endtask

   typedef struct {
      int gap;
      bit clr;
      bit lk;
      bit er;
      int ec;
      int per;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int gap;
      rst      = 1'b1;
      pluse_us = 1'b0;
      clr_err  = 1'b0;
      ms_seen  = 0;
      model_reset();

      tbl[0]  = '{5,          0, 0, 0, 0, 0};
      tbl[1]  = '{B_EXP,      0, 0, 0, 0, B_EXP};
      tbl[2]  = '{B_EXP,      0, 0, 0, 0, B_EXP};
      tbl[3]  = '{B_EXP,      0, 0, 0, 0, B_EXP};
      tbl[4]  = '{B_EXP,      0, 1, 0, 0, B_EXP};
      tbl[5]  = '{B_EXP - 1,  0, 1, 0, 0, B_EXP - 1};
      tbl[6]  = '{B_EXP + 1,  0, 1, 0, 0, B_EXP + 1};
      tbl[7]  = '{B_EXP + 2,  0, 0, 1, 1, B_EXP + 2};
      tbl[8]  = '{B_EXP,      0, 0, 1, 1, B_EXP};
      tbl[9]  = '{B_EXP,      0, 0, 1, 1, B_EXP};
      tbl[10] = '{B_EXP,      0, 0, 1, 1, B_EXP};
      tbl[11] = '{B_EXP,      0, 1, 1, 1, B_EXP};
      tbl[12] = '{B_EXP - 2,  0, 0, 1, 2, B_EXP - 2};
      tbl[13] = '{5,          0, 0, 1, 2, 5};
      tbl[14] = '{B_EXP,      0, 0, 1, 2, B_EXP};
      tbl[15] = '{B_EXP,      0, 0, 1, 2, B_EXP};
      tbl[16] = '{B_EXP,      0, 0, 1, 2, B_EXP};
      tbl[17] = '{B_EXP,      0, 1, 1, 2, B_EXP};
      tbl[18] = '{B_EXP,      1, 1, 0, 0, B_EXP};
      tbl[19] = '{1,          1, 0, 1, 1, 1};

      #1;
      chk("reset_outputs", 32'({locked, err, err_cnt, period, pluse_ms}), 32'd0);
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst = 1'b0;
      model_reset();

      // Nominal lock, tolerance edges, relock, clr_err alone and in collision
      for (int i = 0; i < 20; i++) begin
         pulse_after(tbl[i].gap, tbl[i].clr);
         chk($sformatf("vec%0d_locked", i),  32'(locked),  32'(tbl[i].lk));
         chk($sformatf("vec%0d_err", i),     32'(err),     32'(tbl[i].er));
         chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].ec));
         chk($sformatf("vec%0d_period", i),  32'(period),  32'(tbl[i].per));
      end

      // Missing tick while locked
      relock();
      chk("tmo_locked_before", 32'(locked), 32'd1);
      for (int i = 1; i < B_TO; i++) step(1'b0, 1'b0);
      chk("tmo_locked_at_limit_minus1", 32'(locked), 32'd1);
      chk("tmo_errcnt_before", 32'(err_cnt), 32'd1);
      step(1'b0, 1'b0);
      chk("tmo_locked_after", 32'(locked), 32'd0);
      chk("tmo_errcnt_after", 32'(err_cnt), 32'd2);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
      chk("tmo_errcnt_holds", 32'(err_cnt), 32'd2);

      // 1 ms tick at nominal rate
      pulse_after(7, 1'b0);
      relock();
      chk("ms_locked", 32'(locked), 32'd1);
      ms_seen = 0;
      for (int i = 0; i < 2 * B_MS; i++) pulse_after(B_EXP, 1'b0);
      chk("ms_tick_count", 32'(ms_seen), 32'd2);
      chk("ms_tick_spacing", 32'(ms_stamp[1] - ms_stamp[0]), 32'(B_MS * B_EXP));

      // Bad period mid-count restarts the ms count after relock
      ms_seen = 0;
      for (int i = 0; i < B_MS / 2; i++) pulse_after(B_EXP, 1'b0);
      pulse_after(B_EXP + 3, 1'b0);
      relock();
      for (int i = 0; i < B_MS - 1; i++) pulse_after(B_EXP, 1'b0);
      chk("ms_none_before_full_count", 32'(ms_seen), 32'd0);
      pulse_after(B_EXP, 1'b0);
      chk("ms_tick_after_full_count", 32'(ms_seen), 32'd1);

      // Fault saturation, then clr_err alone and in collision
      for (int k = 0; k < 300; k++) begin
         relock();
         pulse_after(1, 1'b0);
      end
      chk("sat_err_cnt", 32'(err_cnt), 32'd255);
      chk("sat_err", 32'(err), 32'd1);
      step(1'b0, 1'b1);
      chk("clr_err_flag", 32'(err), 32'd0);
      chk("clr_err_cnt", 32'(err_cnt), 32'd0);
      relock();
      pulse_after(1, 1'b1);
      chk("collide_err", 32'(err), 32'd1);
      chk("collide_err_cnt", 32'(err_cnt), 32'd1);

      // Asynchronous reset between clock edges while locked
      relock();
      chk("arst_pre_locked", 32'(locked), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_outputs_immediate", 32'({locked, err, err_cnt, period, pluse_ms}), 32'd0);
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst = 1'b0;
      model_reset();
      pulse_after(30, 1'b0);
      chk("arst_first_pulse_err", 32'(err), 32'd0);
      chk("arst_first_pulse_period", 32'(period), 32'd0);
      pulse_after(B_EXP, 1'b0);
      chk("arst_second_pulse_period", 32'(period), 32'(B_EXP));
      chk("arst_second_pulse_locked", 32'(locked), 32'd0);

      // Random gaps and clears, checked by the per-cycle model comparison
      for (int k = 0; k < 600; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 60)      gap = int'($urandom_range(B_EXP - 1, B_EXP + 1));
         else if (r < 75) gap = ($urandom_range(0, 1) == 1) ? B_EXP + int'($urandom_range(2, 3))
                                                              : B_EXP - int'($urandom_range(2, 3));
         else if (r < 82) gap = 1;
         else if (r < 90) gap = int'($urandom_range(2, B_EXP - 2));
         else if (r < 96) gap = B_TO + int'($urandom_range(0, 20));
         else             gap = int'($urandom_range(B_EXP + 4, B_TO - 1));
         for (int i = 1; i < gap; i++) step(1'b0, $urandom_range(0, 63) == 0);
         step(1'b1, $urandom_range(0, 15) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pluse_us_chk.md
Name: pluse_us_chk

Overview:
- Monitor on the consumer side of the 1 us tick: measures the clk_sys cycle count between consecutive pluse_us pulses and checks it against the expected period.
- Declares lock after a run of good periods and flags faults; a fault is a bad period or a missing tick.
- Derives a 1 ms tick (pluse_ms) from locked pluse_us pulses for slow housekeeping timers.
- Sits beside the clock/reset top, in the clk_sys domain.

Parameters:
- EXP_CYC, 100, expected clk_sys cycles per pluse_us period.
- TOL, 1, allowed deviation in cycles; a period is good if |meas - EXP_CYC| <= TOL.
- LOCK_CNT, 4, consecutive good periods needed to assert locked (1..15).
- TIMEOUT, 255, gap count that declares a missing tick; must satisfy EXP_CYC+TOL < TIMEOUT <= 255.
- MS_DIV, 1000, locked pluse_us pulses per pluse_ms.

Ports:
- clk_sys  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- pluse_us  in  1  1 us tick, sampled each clk_sys cycle; every high cycle is one pulse event.
- clr_err  in  1  one-cycle clear of err and err_cnt.
- locked  out  1  period stable.
- err  out  1  sticky fault flag.
- err_cnt  out  8  fault count, saturating at 255.
- period  out  8  last measured period in cycles.
- pluse_ms  out  1  one-cycle 1 ms tick.

Behaviour:
- Reset (async, rst=1): state=SEARCH; gap counter g=0; good_cnt=0; ms_cnt=0; all outputs 0.
- Gap counter g (8 bit):
  - On a pulse cycle, g<=1.
  - Otherwise g<=g+1, saturating at TIMEOUT.
  - The measured period is the value of g in a pulse cycle, so pulses at cycles t and t+100 give meas=100.
- period register:
  - Loads meas on every pulse except the first pulse in SEARCH.
  - Holds its value otherwise.
- States: SEARCH, ACQ, LOCKED.
- SEARCH:
  - A pulse moves to ACQ with good_cnt=0.
  - No timeout check in this state.
- ACQ:
  - Pulse with a good meas: good_cnt+1. When good_cnt reaches LOCK_CNT, move to LOCKED.
  - Pulse with a bad meas: good_cnt=0, stay in ACQ, no error raised.
  - g==TIMEOUT with no pulse: move to SEARCH, no error raised.
- LOCKED:
  - Pulse with a good meas: stay in LOCKED.
  - Pulse with a bad meas: fault event; move to ACQ with good_cnt=0.
  - g==TIMEOUT with no pulse: fault event; move to SEARCH.
  - The timeout fault fires once; g stays saturated until the next pulse.
- locked is registered and equals (state==LOCKED). It rises the cycle after the LOCK_CNT-th good pulse is sampled and falls the cycle after the fault event.
- Fault event: err<=1; err_cnt<=err_cnt+1, saturating at 255.
- clr_err: err<=0 and err_cnt<=0. If clr_err and a fault event occur in the same cycle, the fault wins: err=1, err_cnt=1.
- ms_cnt (10 bit):
  - Counts pulses only while in LOCKED with a good meas.
  - When ms_cnt==MS_DIV-1 and a good pulse arrives, ms_cnt<=0 and pluse_ms=1 for one cycle on the next cycle.
  - Leaving LOCKED clears ms_cnt to 0.
- Consecutive high cycles on pluse_us:
  - The second cycle gives meas=1, which is bad.
  - In LOCKED this is a fault.
- Reset asserted mid-operation returns everything to reset values immediately; counting restarts in SEARCH after rst falls.

Test Plan:
- Nominal lock: rst released, pluse_us every 100 cycles -> period=100 after the 2nd pulse; locked=1 the cycle after the 5th pulse; err=0, err_cnt=0.
- Tolerance edges while locked: periods of 99 and 101 -> stay locked, err=0. A period of 102 -> locked falls the cycle after that pulse; err=1, err_cnt=1, period=102. Relock after 4 more 100-cycle periods.
- Missing tick: locked, then pulses stop -> g reaches 255 at 255 cycles after the last pulse; fault that cycle; locked=0 and err_cnt=1 next cycle; state SEARCH; err_cnt stays 1 while pulses remain absent.
- 1 ms tick: locked at nominal 100-cycle rate for 2000 further pulses -> exactly 2 pluse_ms pulses, each one cycle wide, 100000 cycles apart. A bad period injected mid-count -> no pluse_ms until 1000 good locked pulses after relock.
- clr_err collision and saturation:
  - 300 induced faults -> err_cnt=255.
  - clr_err alone -> err=0, err_cnt=0.
  - clr_err in the same cycle as a fault -> err=1, err_cnt=1.
- Async reset mid-lock: assert rst between clock edges -> locked, err, err_cnt, period and pluse_ms go to 0 without waiting for a clock edge. After release, the first pulse enters ACQ and no error is raised.
